// File: rtl/freq_uart_reporter.sv
// rtl/freq_uart_reporter.sv - BCD frequency result to ASCII line over 8N1 UART (option: FREQ_UART_HZ_SUFFIX_EN)
module freq_uart_reporter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

`ifdef FREQ_UART_HZ_SUFFIX_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 4;
`endif
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [3:0]    frame_ten;
    logic [3:0]    frame_unit;
    logic [3:0]    pend_ten;
    logic [3:0]    pend_unit;
    logic          pend_valid;

    logic          digits_bad;
    logic [7:0]    ten_char;
    logic [7:0]    unit_char;
    logic [7:0]    cur_byte;
    logic          bit_done;
    logic          final_stop;

    // Character currently on the wire, chosen from the stable frame register
    always_comb begin
        digits_bad = (frame_ten > 4'd9) || (frame_unit > 4'd9);
        ten_char   = digits_bad ? 8'h2D : 8'h30 + {4'h0, frame_ten};
        unit_char  = digits_bad ? 8'h2D : 8'h30 + {4'h0, frame_unit};
        cur_byte   = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = ten_char;
            3'd1:    cur_byte = unit_char;
`ifdef FREQ_UART_HZ_SUFFIX_EN
            3'd2:    cur_byte = 8'h48;
            3'd3:    cur_byte = 8'h7A;
            3'd4:    cur_byte = 8'h0D;
`else
            3'd2:    cur_byte = 8'h0D;
`endif
            default: cur_byte = 8'h0A;
        endcase
        bit_done   = (clk_cnt == CNT_MAX);
        final_stop = (state == STOP) && bit_done && (byte_idx == LAST_BYTE);
    end

    // Transmit FSM; a load in the final stop cycle chains straight into the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            frame_ten  <= '0;
            frame_unit <= '0;
            pend_ten   <= '0;
            pend_unit  <= '0;
            pend_valid <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load && (state != IDLE) && !final_stop) begin
                pend_ten   <= ten_count;
                pend_unit  <= unit_count;
                pend_valid <= 1'b1;
                overrun    <= pend_valid;
            end
            case (state)
                IDLE: begin
                    if (load || pend_valid) begin
                        frame_ten  <= load ? ten_count : pend_ten;
                        frame_unit <= load ? unit_count : pend_unit;
                        overrun    <= load && pend_valid;
                        pend_valid <= 1'b0;
                        state      <= START;
                        clk_cnt    <= '0;
                        bit_idx    <= '0;
                        byte_idx   <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (load || pend_valid) begin
                            frame_ten  <= load ? ten_count : pend_ten;
                            frame_unit <= load ? unit_count : pend_unit;
                            overrun    <= load && pend_valid;
                            pend_valid <= 1'b0;
                            byte_idx   <= '0;
                            state      <= START;
                            tx         <= 1'b0;
                        end else begin
                            byte_idx <= '0;
                            state    <= IDLE;
                            tx       <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_uart_reporter.sv
// tb/tb_freq_uart_reporter.sv - randomized bench for freq_uart_reporter against a bit-stream model
module tb_freq_uart_reporter;

    localparam int CPB = 4;
`ifdef FREQ_UART_HZ_SUFFIX_EN
    localparam int FL = 6;
`else
    localparam int FL = 4;
`endif

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ten = 4'd0;
    logic [3:0] unit = 4'd0;
    logic       tx;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad = 0;
    bit armed = 0;

    freq_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ten_count  (ten),
        .unit_count (unit),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: the line is a queue of future tx levels, one per cycle
    bit         exp_bits[$];
    bit         pend_v = 0;
    logic [3:0] pt = 4'd0;
    logic [3:0] pu = 4'd0;
    logic       exp_tx = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_ov = 1'b0;

    task automatic push_frame(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] chars[$];
        if (t > 4'd9 || u > 4'd9) chars = '{8'h2D, 8'h2D};
        else chars = '{8'h30 + 8'(t), 8'h30 + 8'(u)};
`ifdef FREQ_UART_HZ_SUFFIX_EN
        chars.push_back(8'h48);
        chars.push_back(8'h7A);
`endif
        chars.push_back(8'h0D);
        chars.push_back(8'h0A);
        foreach (chars[i]) begin
            for (int b = -1; b < 9; b++) begin
                for (int k = 0; k < CPB; k++) begin
                    if (b < 0) exp_bits.push_back(1'b0);
                    else if (b > 7) exp_bits.push_back(1'b1);
                    else exp_bits.push_back(chars[i][b]);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            exp_bits.delete();
            pend_v = 0;
            exp_ov = 1'b0;
        end else begin
            exp_ov = 1'b0;
            if (exp_bits.size() > 0) void'(exp_bits.pop_front());
            if (load) begin
                exp_ov = pend_v;
                if (exp_bits.size() > 0) begin
                    pend_v = 1;
                    pt = ten;
                    pu = unit;
                end else begin
                    pend_v = 0;
                    push_frame(ten, unit);
                end
            end else if (exp_bits.size() == 0 && pend_v) begin
                pend_v = 0;
                push_frame(pt, pu);
            end
        end
        exp_tx   = (exp_bits.size() > 0) ? exp_bits[0] : 1'b1;
        exp_busy = (exp_bits.size() > 0);
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            total += 3;
            if (tx !== exp_tx) begin
                bad++;
                $display("FAIL cycle_tx t=%0t: got %b want %b", $time, tx, exp_tx);
            end
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL cycle_busy t=%0t: got %b want %b", $time, busy, exp_busy);
            end
            if (overrun !== exp_ov) begin
                bad++;
                $display("FAIL cycle_overrun t=%0t: got %b want %b", $time, overrun, exp_ov);
            end
        end
    end

    // UART receiver, busy-run length and overrun counter
    logic [7:0] rx_q[$];
    bit         rx_active = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         run = 0;
    int         last_run = 0;
    int         ov_count = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_active = 0;
            run = 0;
        end else begin
            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                    rx_sh[rx_cnt / CPB - 1] = tx;
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    total++;
                    if (tx !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: got %b want 1", tx);
                    end
                    rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
            if (busy === 1'b1) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (overrun === 1'b1) ov_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [3:0] t, input logic [3:0] u);
        load = 1'b1;
        ten = t;
        unit = u;
        step();
        load = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_bytes(input string name, input bq_t want);
        int idx;
        idx = -1;
        if (rx_q.size() != want.size()) idx = -2;
        else foreach (want[i]) if (idx == -1 && rx_q[i] !== want[i]) idx = i;
        total++;
        if (idx == -2) begin
            bad++;
            $display("FAIL %s: got %0d bytes want %0d bytes", name, rx_q.size(), want.size());
        end else if (idx >= 0) begin
            bad++;
            $display("FAIL %s: byte %0d got %h want %h", name, idx, rx_q[idx], want[idx]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: busy got %b want 0", name, busy);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        bq_t e;
        repeat (3) step();
        reset = 1'b0;
        armed = 1;

        // Idle after reset
        repeat (200) step();
        chk("idle_tx", int'(tx), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_overrun_count", ov_count, 0);

        // 4/2 with latency and duration
        rx_q.delete();
        chk("tx_before_load", int'(tx), 1);
        pulse_load(4'd4, 4'd2);
        chk("tx_fall", int'(tx), 0);
        chk("busy_rise", int'(busy), 1);
        wait_idle("f42");
        chk("busy_len_42", last_run, FL * 10 * CPB);
`ifdef FREQ_UART_HZ_SUFFIX_EN
        e = '{8'h34, 8'h32, 8'h48, 8'h7A, 8'h0D, 8'h0A};
`else
        e = '{8'h34, 8'h32, 8'h0D, 8'h0A};
`endif
        chk_bytes("bytes_42", e);

        // Overflow digits
        rx_q.delete();
        pulse_load(4'd12, 4'd7);
        wait_idle("f127");
`ifdef FREQ_UART_HZ_SUFFIX_EN
        e = '{8'h2D, 8'h2D, 8'h48, 8'h7A, 8'h0D, 8'h0A};
`else
        e = '{8'h2D, 8'h2D, 8'h0D, 8'h0A};
`endif
        chk_bytes("bytes_127", e);

        // Three loads during one frame
        rx_q.delete();
        ov_count = 0;
        pulse_load(4'd1, 4'd1);
        repeat (10) step();
        pulse_load(4'd2, 4'd2);
        repeat (10) step();
        pulse_load(4'd3, 4'd3);
        wait_idle("triple");
        chk("triple_overrun_count", ov_count, 1);
        chk("triple_busy_len", last_run, 2 * FL * 10 * CPB);
`ifdef FREQ_UART_HZ_SUFFIX_EN
        e = '{8'h31, 8'h31, 8'h48, 8'h7A, 8'h0D, 8'h0A, 8'h33, 8'h33, 8'h48, 8'h7A, 8'h0D, 8'h0A};
`else
        e = '{8'h31, 8'h31, 8'h0D, 8'h0A, 8'h33, 8'h33, 8'h0D, 8'h0A};
`endif
        chk_bytes("bytes_triple", e);

        // Load exactly in the final stop cycle chains with no gap
        rx_q.delete();
        pulse_load(4'd5, 4'd5);
        repeat (FL * 10 * CPB - 1) step();
        pulse_load(4'd6, 4'd6);
        wait_idle("chain");
        chk("chain_busy_len", last_run, 2 * FL * 10 * CPB);
        chk("chain_byte_count", rx_q.size(), 2 * FL);

        // Reset during DATA of byte 1
        pulse_load(4'd7, 4'd7);
        repeat (11 * CPB + 2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        repeat (5) step();
        rx_q.delete();
        pulse_load(4'd0, 4'd9);
        wait_idle("f09");
`ifdef FREQ_UART_HZ_SUFFIX_EN
        e = '{8'h30, 8'h39, 8'h48, 8'h7A, 8'h0D, 8'h0A};
`else
        e = '{8'h30, 8'h39, 8'h0D, 8'h0A};
`endif
        chk_bytes("bytes_09", e);

        // Load together with reset is ignored
        reset = 1'b1;
        load = 1'b1;
        ten = 4'd1;
        unit = 4'd1;
        step();
        reset = 1'b0;
        load = 1'b0;
        repeat (3) step();
        chk("load_with_reset_busy", int'(busy), 0);

        // 5/0 frame length
        rx_q.delete();
        pulse_load(4'd5, 4'd0);
        wait_idle("f50");
        chk("busy_len_50", last_run, FL * 10 * CPB);
`ifdef FREQ_UART_HZ_SUFFIX_EN
        e = '{8'h35, 8'h30, 8'h48, 8'h7A, 8'h0D, 8'h0A};
`else
        e = '{8'h35, 8'h30, 8'h0D, 8'h0A};
`endif
        chk_bytes("bytes_50", e);

        // Randomized loads, gaps and occasional resets
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 70)) step();
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                load = 1'($urandom_range(0, 1));
                step();
                reset = 1'b0;
                load = 1'b0;
            end else begin
                pulse_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        wait_idle("random_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
